// File: rtl/countdown_timer_pkg.sv
// Shared types and defaults for the countdown timer.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_PRESCALE = 4;

endpackage

// File: rtl/countdown_timer_tick_div.sv
// Prescaler: counts enabled cycles 0..PRESCALE-1 and emits a one-cycle tick on the wrap.
// Combinational tick from registered phase; clr returns the phase to 0 and wins over en.
module tick_div #(
  parameter int PRESCALE = countdown_timer_pkg::DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable one-shot/periodic down counter with registered count and one-cycle tc pulse.
// Optional enable prescaler built only when COUNTDOWN_TIMER_PRESCALE_EN is defined.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             tc_q;
  logic             tick;

`ifdef COUNTDOWN_TIMER_PRESCALE_EN
  // Prescaler phase only advances while running so idle/expired time never skews it.
  tick_div #(
    .PRESCALE(PRESCALE)
  ) u_tick_div (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en && (state_q == RUN)),
    .clr  (load),
    .tick (tick)
  );
`else
  localparam int prescale_unused = PRESCALE;
  assign tick = en;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      if (load) begin
        count_q  <= load_val;
        reload_q <= load_val;
        state_q  <= (load_val != '0) ? RUN : IDLE;
      end else if ((state_q == RUN) && tick) begin
        if (count_q > WIDTH'(1)) begin
          count_q <= count_q - WIDTH'(1);
        end else if (count_q == WIDTH'(1)) begin
          tc_q <= 1'b1;
          if (auto_reload) begin
            count_q <= reload_q;
          end else begin
            count_q <= '0;
            state_q <= EXPIRED;
          end
        end
      end
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == EXPIRED);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer; outputs sampled 1ns after each rising edge.
module tb_countdown_timer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         load;
  logic [W-1:0] load_val;
  logic         auto_reload;
  logic [W-1:0] count;
  logic         tc;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;

  countdown_timer #(
    .WIDTH   (W),
    .PRESCALE(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .load_val   (load_val),
    .auto_reload(auto_reload),
    .count      (count),
    .tc         (tc),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Observation order below is {count, tc, busy, done}.
  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; load = 1'b0; load_val = '0; auto_reload = 1'b0;
    step();
    step();
    total++;
    if ({count, tc, busy, done} !== {8'd0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: got %h want %h", {count, tc, busy, done}, {8'd0, 3'b000});
    end
    #3 rst_n = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({count, tc, busy, done} !== {8'd0, 3'b000}) begin
        bad++;
        $display("FAIL idle_ignores_en[%0d]: got %h want %h", i, {count, tc, busy, done}, {8'd0, 3'b000});
      end
    end
  endtask

  task automatic test_oneshot();
    logic [W-1:0] exp_c [5] = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd0};
    logic [2:0]   exp_f [5] = '{3'b010, 3'b010, 3'b010, 3'b101, 3'b001};
    load = 1'b1; load_val = 8'd3; auto_reload = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      load = 1'b0;
      total++;
      if ({count, tc, busy, done} !== {exp_c[i], exp_f[i]}) begin
        bad++;
        $display("FAIL oneshot[%0d]: got %h want %h", i, {count, tc, busy, done}, {exp_c[i], exp_f[i]});
      end
    end
  endtask

  task automatic test_periodic();
    logic [W-1:0] ec;
    logic         et;
    load = 1'b1; load_val = 8'd2; auto_reload = 1'b1; en = 1'b1;
    step();
    load = 1'b0;
    total++;
    if ({count, tc, busy, done} !== {8'd2, 3'b010}) begin
      bad++;
      $display("FAIL periodic_load: got %h want %h", {count, tc, busy, done}, {8'd2, 3'b010});
    end
    for (int k = 1; k <= 8; k++) begin
      step();
      ec = (k % 2 == 1) ? 8'd1 : 8'd2;
      et = (k % 2 == 0);
      total++;
      if ({count, tc, busy, done} !== {ec, et, 2'b10}) begin
        bad++;
        $display("FAIL periodic[%0d]: got %h want %h", k, {count, tc, busy, done}, {ec, et, 2'b10});
      end
    end
  endtask

  task automatic test_collision_zero();
    load = 1'b1; load_val = 8'd5; auto_reload = 1'b0; en = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) step();
    total++;
    if ({count, tc, busy, done} !== {8'd1, 3'b010}) begin
      bad++;
      $display("FAIL collision_pre: got %h want %h", {count, tc, busy, done}, {8'd1, 3'b010});
    end
    load = 1'b1; load_val = 8'd5;
    step();
    load = 1'b0;
    total++;
    if ({count, tc, busy, done} !== {8'd5, 3'b010}) begin
      bad++;
      $display("FAIL collision_load_wins: got %h want %h", {count, tc, busy, done}, {8'd5, 3'b010});
    end
    step();
    total++;
    if ({count, tc, busy, done} !== {8'd4, 3'b010}) begin
      bad++;
      $display("FAIL collision_resume: got %h want %h", {count, tc, busy, done}, {8'd4, 3'b010});
    end
    load = 1'b1; load_val = 8'd0;
    step();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({count, tc, busy, done} !== {8'd0, 3'b000}) begin
        bad++;
        $display("FAIL zero_load[%0d]: got %h want %h", i, {count, tc, busy, done}, {8'd0, 3'b000});
      end
      step();
    end
  endtask

  task automatic test_enable();
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
    logic en_seq [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    int           n_en = 0;
    logic [W-1:0] ec;
    logic         et;
    load = 1'b1; load_val = 8'd2; auto_reload = 1'b0; en = 1'b0;
    step();
    load = 1'b0;
    for (int i = 0; i < 9; i++) begin
      en = en_seq[i];
      step();
      if (en_seq[i]) n_en++;
      ec = (n_en < 4) ? 8'd2 : (n_en < 8) ? 8'd1 : 8'd0;
      et = en_seq[i] && (n_en == 8);
      total++;
      if ({count, tc} !== {ec, et}) begin
        bad++;
        $display("FAIL prescale[%0d]: got %h want %h", i, {count, tc}, {ec, et});
      end
    end
`else
    logic         en_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] exp_c  [4] = '{8'd2, 8'd2, 8'd1, 8'd0};
    logic [2:0]   exp_f  [4] = '{3'b010, 3'b010, 3'b010, 3'b101};
    load = 1'b1; load_val = 8'd3; auto_reload = 1'b0; en = 1'b0;
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en = en_seq[i];
      step();
      total++;
      if ({count, tc, busy, done} !== {exp_c[i], exp_f[i]}) begin
        bad++;
        $display("FAIL enable[%0d]: got %h want %h", i, {count, tc, busy, done}, {exp_c[i], exp_f[i]});
      end
    end
`endif
  endtask

  task automatic test_async_reset();
    load = 1'b1; load_val = 8'd7; auto_reload = 1'b0; en = 1'b1;
    step();
    load = 1'b0;
    total++;
    if ({count, tc, busy, done} !== {8'd7, 3'b010}) begin
      bad++;
      $display("FAIL areset_pre: got %h want %h", {count, tc, busy, done}, {8'd7, 3'b010});
    end
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({count, tc, busy, done} !== {8'd0, 3'b000}) begin
      bad++;
      $display("FAIL areset_immediate: got %h want %h", {count, tc, busy, done}, {8'd0, 3'b000});
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({count, tc, busy, done} !== {8'd0, 3'b000}) begin
        bad++;
        $display("FAIL areset_idle[%0d]: got %h want %h", i, {count, tc, busy, done}, {8'd0, 3'b000});
      end
    end
    load = 1'b1; load_val = 8'd2;
    step();
    load = 1'b0;
    total++;
    if ({count, tc, busy, done} !== {8'd2, 3'b010}) begin
      bad++;
      $display("FAIL areset_reload: got %h want %h", {count, tc, busy, done}, {8'd2, 3'b010});
    end
  endtask

  task automatic test_back_to_back_reload1();
    load = 1'b1; load_val = 8'd1; auto_reload = 1'b1; en = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({count, tc, busy, done} !== {8'd1, 3'b110}) begin
        bad++;
        $display("FAIL reload1[%0d]: got %h want %h", i, {count, tc, busy, done}, {8'd1, 3'b110});
      end
    end
    auto_reload = 1'b0;
    step();
    total++;
    if ({count, tc, busy, done} !== {8'd0, 3'b101}) begin
      bad++;
      $display("FAIL reload1_stop: got %h want %h", {count, tc, busy, done}, {8'd0, 3'b101});
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_collision_zero();
    test_enable();
    test_async_reset();
`ifndef COUNTDOWN_TIMER_PRESCALE_EN
    test_back_to_back_reload1();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
